itim_port_arbiter: RTL and testbench

// - Shares one single-port, synchronous-read ITIM between the core fetch port (F) and the core load port (D).
// - Lets the LSU read .rodata/constants from ITIM while the fetch path keeps running.
// - Sits between the core and the ITIM array. Issues at most one ITIM read per cycle; read data returns 1 cycle after grant.

---
 rtl/itim_pkg.sv | 21 ++
 rtl/itim_window_chk.sv | 27 ++
 rtl/itim_port_arbiter.sv | 117 +++++++++++
 tb/tb_itim_port_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/itim_pkg.sv
// Shared definitions for the ITIM fetch/load port arbiter.
package itim_pkg;

    localparam int          ROM_ADDR_BITS_DEF = 10;
    localparam logic [31:0] ITIM_BASE_DEF     = 32'h0000_0000;
    localparam int          MAX_D_STREAK_DEF  = 4;
    localparam int          STREAK_W          = 4;

    typedef enum logic {
        PORT_F = 1'b0,
        PORT_D = 1'b1
    } port_e;

    // One outstanding read: which port owns the response and whether it is an error reply.
    typedef struct packed {
        logic  valid;
        port_e port;
        logic  err;
    } issue_tag_t;

endpackage

// File: rtl/itim_window_chk.sv
// Combinational ITIM window/alignment check and word-address extraction for one requester.
module itim_window_chk
    import itim_pkg::*;
#(
    parameter int          ROM_ADDR_BITS = ROM_ADDR_BITS_DEF,
    parameter logic [31:0] ITIM_BASE     = ITIM_BASE_DEF,
    parameter bit          CHECK_ALIGN   = 1'b0
) (
    input  logic [31:0]              addr,
    output logic                     err,
    output logic [ROM_ADDR_BITS-1:0] word_addr
);

    // 33-bit limit so the window size stays representable for any address width.
    localparam logic [32:0] WINDOW_BYTES = 33'(1) << (ROM_ADDR_BITS + 2);

    logic [31:0] offset;
    logic        in_window;
    logic        misaligned;

    assign offset     = addr - ITIM_BASE;
    assign in_window  = ({1'b0, offset} < WINDOW_BYTES);
    assign misaligned = CHECK_ALIGN && (addr[1:0] != 2'b00);
    assign err        = !in_window || misaligned;
    assign word_addr  = offset[ROM_ADDR_BITS+1:2];

endmodule

// File: rtl/itim_port_arbiter.sv
// Shares one synchronous-read ITIM between the fetch (F) and load (D) ports.
// D has priority, bounded by a streak limit so a waiting fetch is never starved.
module itim_port_arbiter
    import itim_pkg::*;
#(
    parameter int          ROM_ADDR_BITS = ROM_ADDR_BITS_DEF,
    parameter logic [31:0] ITIM_BASE     = ITIM_BASE_DEF,
    parameter int          MAX_D_STREAK  = MAX_D_STREAK_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     f_req_valid,
    input  logic [31:0]              f_req_addr,
    output logic                     f_req_ready,
    input  logic                     f_flush,
    output logic                     f_rsp_valid,
    output logic [31:0]              f_rsp_rdata,
    output logic                     f_rsp_err,
    input  logic                     d_req_valid,
    input  logic [31:0]              d_req_addr,
    output logic                     d_req_ready,
    output logic                     d_rsp_valid,
    output logic [31:0]              d_rsp_rdata,
    output logic                     d_rsp_err,
    output logic                     mem_en,
    output logic [ROM_ADDR_BITS-1:0] mem_addr,
    input  logic [31:0]              mem_rdata
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    logic                     f_err;
    logic                     d_err;
    logic [ROM_ADDR_BITS-1:0] f_word;
    logic [ROM_ADDR_BITS-1:0] d_word;
    logic                     f_grant;
    logic                     d_grant;
    logic                     rsp_live;
    logic [STREAK_W-1:0]      streak_q;
    issue_tag_t               tag_q;

    itim_window_chk #(
        .ROM_ADDR_BITS (ROM_ADDR_BITS),
        .ITIM_BASE     (ITIM_BASE),
        .CHECK_ALIGN   (1'b1)
    ) u_f_chk (
        .addr      (f_req_addr),
        .err       (f_err),
        .word_addr (f_word)
    );

    itim_window_chk #(
        .ROM_ADDR_BITS (ROM_ADDR_BITS),
        .ITIM_BASE     (ITIM_BASE),
        .CHECK_ALIGN   (1'b0)
    ) u_d_chk (
        .addr      (d_req_addr),
        .err       (d_err),
        .word_addr (d_word)
    );

    // Nothing is granted while reset is held, so every output reads 0 in the reset cycle.
    always_comb begin
        f_grant = 1'b0;
        d_grant = 1'b0;
        if (!rst) begin
            if (f_req_valid && (!d_req_valid || streak_q == STREAK_MAX)) begin
                f_grant = 1'b1;
            end else if (d_req_valid) begin
                d_grant = 1'b1;
            end
        end
    end

    assign f_req_ready = f_grant;
    assign d_req_ready = d_grant;

    // Out-of-window grants are accepted but never touch the array.
    always_comb begin
        mem_en   = (f_grant && !f_err) || (d_grant && !d_err);
        mem_addr = '0;
        if (f_grant) begin
            mem_addr = f_word;
        end else if (d_grant) begin
            mem_addr = d_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q <= '0;
            tag_q    <= '0;
        end else begin
            tag_q.valid <= f_grant || d_grant;
            tag_q.port  <= d_grant ? PORT_D : PORT_F;
            tag_q.err   <= (f_grant && f_err) || (d_grant && d_err);

            if (!f_req_valid || f_grant) begin
                streak_q <= '0;
            end else if (d_grant && streak_q != STREAK_MAX) begin
                streak_q <= streak_q + 1'b1;
            end
        end
    end

    // A reset landing in the response cycle drops the in-flight reply.
    assign rsp_live = !rst && tag_q.valid;

    assign f_rsp_valid = rsp_live && (tag_q.port == PORT_F) && !f_flush;
    assign f_rsp_err   = f_rsp_valid && tag_q.err;
    assign f_rsp_rdata = (f_rsp_valid && !tag_q.err) ? mem_rdata : '0;

    assign d_rsp_valid = rsp_live && (tag_q.port == PORT_D);
    assign d_rsp_err   = d_rsp_valid && tag_q.err;
    assign d_rsp_rdata = (d_rsp_valid && !tag_q.err) ? mem_rdata : '0;

endmodule

// File: tb/tb_itim_port_arbiter.sv
// Self-checking bench for itim_port_arbiter: vector table plus scoreboarded multi-cycle sequences.
module tb_itim_port_arbiter;

    localparam int          RAB  = 10;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           f_req_valid = 1'b0;
    logic [31:0]    f_req_addr = '0;
    logic           f_req_ready;
    logic           f_flush = 1'b0;
    logic           f_rsp_valid;
    logic [31:0]    f_rsp_rdata;
    logic           f_rsp_err;
    logic           d_req_valid = 1'b0;
    logic [31:0]    d_req_addr = '0;
    logic           d_req_ready;
    logic           d_rsp_valid;
    logic [31:0]    d_rsp_rdata;
    logic           d_rsp_err;
    logic           mem_en;
    logic [RAB-1:0] mem_addr;
    logic [31:0]    mem_rdata = '0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        f;
        logic        d;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        logic        fv;
        logic [31:0] fa;
        logic        dv;
        logic [31:0] da;
        logic        fl;
        logic        efr;
        logic        edr;
    } vec_t;

    rsp_t sb[$];
    vec_t tbl[19];

    always #5 clk = ~clk;

    itim_port_arbiter #(
        .ROM_ADDR_BITS (RAB),
        .ITIM_BASE     (BASE),
        .MAX_D_STREAK  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .f_req_valid (f_req_valid),
        .f_req_addr  (f_req_addr),
        .f_req_ready (f_req_ready),
        .f_flush     (f_flush),
        .f_rsp_valid (f_rsp_valid),
        .f_rsp_rdata (f_rsp_rdata),
        .f_rsp_err   (f_rsp_err),
        .d_req_valid (d_req_valid),
        .d_req_addr  (d_req_addr),
        .d_req_ready (d_req_ready),
        .d_rsp_valid (d_rsp_valid),
        .d_rsp_rdata (d_rsp_rdata),
        .d_rsp_err   (d_rsp_err),
        .mem_en      (mem_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata)
    );

    function automatic logic [31:0] mem_word(input logic [RAB-1:0] w);
        return 32'h5A00_0000 + ({22'b0, w} * 32'h0001_0001);
    endfunction

    // Synchronous-read ITIM model; garbage when not enabled so leaks show up.
    always @(posedge clk) mem_rdata <= mem_en ? mem_word(mem_addr) : 32'hDEAD_BEEF;

    function automatic logic win_ok(input logic [31:0] a, input logic is_f);
        logic [31:0] off;
        off = a - BASE;
        return (off < 32'(4 * (1 << RAB))) && !(is_f && (a[1:0] != 2'b00));
    endfunction

    function automatic logic [RAB-1:0] word_of(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) >> 2;
        return off[RAB-1:0];
    endfunction

    function automatic vec_t mk(input logic fv, input logic [31:0] fa, input logic dv,
                                input logic [31:0] da, input logic fl, input logic efr,
                                input logic edr);
        vec_t v;
        v.fv = fv; v.fa = fa; v.dv = dv; v.da = da; v.fl = fl; v.efr = efr; v.edr = edr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic fv, input logic [31:0] fa, input logic dv,
                        input logic [31:0] da, input logic fl, input logic efr, input logic edr);
        rsp_t e;
        rsp_t n;
        logic men;
        logic ok;
        logic fexp;
        @(posedge clk);
        #1;
        rst = r; f_req_valid = fv; f_req_addr = fa; d_req_valid = dv; d_req_addr = da;
        f_flush = fl;
        @(negedge clk);
        e = '{f: 1'b0, d: 1'b0, err: 1'b0, data: 32'h0};
        if (sb.size() > 0) e = sb.pop_front();
        if (r) begin
            chk("rst f_req_ready", f_req_ready, 0);
            chk("rst d_req_ready", d_req_ready, 0);
            chk("rst mem_en", mem_en, 0);
            chk("rst mem_addr", mem_addr, 0);
            chk("rst f_rsp_valid", f_rsp_valid, 0);
            chk("rst f_rsp_err", f_rsp_err, 0);
            chk("rst f_rsp_rdata", f_rsp_rdata, 0);
            chk("rst d_rsp_valid", d_rsp_valid, 0);
            chk("rst d_rsp_err", d_rsp_err, 0);
            chk("rst d_rsp_rdata", d_rsp_rdata, 0);
            sb.delete();
        end else begin
            chk("f_req_ready", f_req_ready, efr);
            chk("d_req_ready", d_req_ready, edr);
            men = (efr && win_ok(fa, 1'b1)) || (edr && win_ok(da, 1'b0));
            chk("mem_en", mem_en, men);
            if (men) chk("mem_addr", mem_addr, efr ? word_of(fa) : word_of(da));
            fexp = e.f && !fl;
            chk("f_rsp_valid", f_rsp_valid, fexp);
            chk("f_rsp_err", f_rsp_err, fexp && e.err);
            chk("f_rsp_rdata", f_rsp_rdata, fexp ? e.data : 32'h0);
            chk("d_rsp_valid", d_rsp_valid, e.d);
            chk("d_rsp_err", d_rsp_err, e.d && e.err);
            chk("d_rsp_rdata", d_rsp_rdata, e.d ? e.data : 32'h0);
            ok     = efr ? win_ok(fa, 1'b1) : win_ok(da, 1'b0);
            n.f    = efr;
            n.d    = edr;
            n.err  = (efr || edr) && !ok;
            n.data = ((efr || edr) && ok) ? mem_word(efr ? word_of(fa) : word_of(da)) : 32'h0;
            sb.push_back(n);
        end
    endtask

    logic [31:0] fa_s;
    logic [31:0] da_s;
    logic        ef;

    initial begin
        tbl[0]  = mk(1, 32'h0000, 0, 32'h0000, 0, 1, 0);
        tbl[1]  = mk(1, 32'h0004, 0, 32'h0000, 0, 1, 0);
        tbl[2]  = mk(1, 32'h0008, 0, 32'h0000, 0, 1, 0);
        tbl[3]  = mk(0, 32'h0000, 0, 32'h0000, 0, 0, 0);
        tbl[4]  = mk(0, 32'h0000, 1, 32'h1000, 0, 0, 1);
        tbl[5]  = mk(0, 32'h0000, 0, 32'h0000, 0, 0, 0);
        tbl[6]  = mk(1, 32'h0006, 0, 32'h0000, 0, 1, 0);
        tbl[7]  = mk(0, 32'h0000, 1, 32'h0006, 0, 0, 1);
        tbl[8]  = mk(0, 32'h0000, 0, 32'h0000, 0, 0, 0);
        tbl[9]  = mk(1, 32'h0010, 0, 32'h0000, 0, 1, 0);
        tbl[10] = mk(0, 32'h0000, 1, 32'h0020, 1, 0, 1);
        tbl[11] = mk(0, 32'h0000, 0, 32'h0000, 1, 0, 0);
        tbl[12] = mk(1, 32'h0014, 0, 32'h0000, 1, 1, 0);
        tbl[13] = mk(0, 32'h0000, 0, 32'h0000, 0, 0, 0);
        tbl[14] = mk(1, 32'h0FFC, 1, 32'h0FFF, 0, 0, 1);
        tbl[15] = mk(1, 32'h0FFC, 0, 32'h0000, 0, 1, 0);
        tbl[16] = mk(1, 32'h1000, 0, 32'h0000, 0, 1, 0);
        tbl[17] = mk(0, 32'h0000, 1, 32'h0FFC, 0, 0, 1);
        tbl[18] = mk(0, 32'h0000, 0, 32'h0000, 0, 0, 0);

        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 32'h40, 1, 32'h80, 0, 0, 0);

        for (int i = 0; i < 19; i++) begin
            step(0, tbl[i].fv, tbl[i].fa, tbl[i].dv, tbl[i].da, tbl[i].fl, tbl[i].efr, tbl[i].edr);
        end

        // Both ports saturated: D wins four times, then the waiting fetch gets one slot.
        fa_s = 32'h40;
        da_s = 32'h100;
        for (int i = 0; i < 10; i++) begin
            ef = (i % 5 == 4);
            step(0, 1, fa_s, 1, da_s, 0, ef, !ef);
            if (ef) fa_s = fa_s + 32'h4;
            else    da_s = da_s + 32'h4;
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset the cycle after an F grant: its response must vanish.
        step(0, 1, 32'h20, 0, 0, 0, 1, 0);
        step(1, 1, 32'h24, 1, 32'h30, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Build a partial streak, reset, then expect a full four-D run again.
        step(0, 1, 32'h80, 1, 32'h200, 0, 0, 1);
        step(0, 1, 32'h80, 1, 32'h204, 0, 0, 1);
        step(1, 1, 32'h80, 1, 32'h208, 0, 0, 0);
        da_s = 32'h300;
        for (int i = 0; i < 5; i++) begin
            ef = (i == 4);
            step(0, 1, 32'h80, 1, da_s, 0, ef, !ef);
            if (!ef) da_s = da_s + 32'h4;
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
